nbit_regfile_onehot: RTL and testbench

//  Register file for the pipelined datapath, directly downstream of the N-bit write-enable demux.
//  The demux turns RegWrite plus the WB destination index into a one-hot enable vector, which this block consumes.
//  Two combinational read ports feed the ID stage.

---
 rtl/nbit_regfile_onehot_pkg.sv | 12 +
 rtl/nbit_defines.svh | 9 +
 rtl/nbit_register.sv | 20 ++
 rtl/nbit_regfile_onehot.sv | 106 ++++++++++
 tb/tb_nbit_regfile_onehot.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/nbit_regfile_onehot_pkg.sv
// Types shared by the register file: classification of the incoming one-hot write enable.
package nbit_regfile_onehot_pkg;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_LEGAL = 2'd1,
    WR_MULTI = 2'd2
  } wrKind_e;

  localparam int DEFAULT_CNT_WIDTH = 16;

endpackage

// File: rtl/nbit_defines.svh
// Shared datapath sizing defaults used by the demux, the register file and the pipeline registers.
`ifndef NBIT_DEFINES_SVH
`define NBIT_DEFINES_SVH

`define NBIT_SELECT_WIDTH 3
`define NBIT_DATA_WIDTH   32
`define NBIT_ZERO_REG     1

`endif

// File: rtl/nbit_register.sv
// DATA_WIDTH storage flop with load enable; q updates one clock after load, cleared asynchronously by rst.
module nbit_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/nbit_regfile_onehot.sv
// One-hot-write register file with two combinational read ports and same-cycle WB->ID bypass.
// Writes commit at posedge clk; reads are zero latency; multi-hot enables are dropped and flagged.
`include "nbit_defines.svh"

module nbit_regfile_onehot
  import nbit_regfile_onehot_pkg::*;
#(
  parameter int SELECT_WIDTH = `NBIT_SELECT_WIDTH,
  parameter int DATA_WIDTH   = `NBIT_DATA_WIDTH,
  parameter int ZERO_REG     = `NBIT_ZERO_REG,
  parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [(1<<SELECT_WIDTH)-1:0]   WrEn,
  input  logic [DATA_WIDTH-1:0]          WrData,
  input  logic [SELECT_WIDTH-1:0]        RdAddrA,
  input  logic [SELECT_WIDTH-1:0]        RdAddrB,
  output logic [DATA_WIDTH-1:0]          RdDataA,
  output logic [DATA_WIDTH-1:0]          RdDataB,
  output logic                           ErrMulti,
  output logic [CNT_WIDTH-1:0]           WrCount
);

  localparam int N = 1 << SELECT_WIDTH;

  logic [DATA_WIDTH-1:0]   regQ [N];
  logic [N-1:0]            load;
  logic [SELECT_WIDTH:0]   onesCnt;
  logic [SELECT_WIDTH-1:0] wrIdx;
  wrKind_e                 wrKind;
  logic                    legal;
  logic                    commit;

  // Popcount and one-hot encode share one pass; wrIdx is only meaningful when legal.
  always_comb begin
    onesCnt = '0;
    wrIdx   = '0;
    for (int i = 0; i < N; i++) begin
      if (WrEn[i]) begin
        onesCnt = onesCnt + 1'b1;
        wrIdx   = wrIdx | SELECT_WIDTH'(i);
      end
    end
  end

  always_comb begin
    wrKind = WR_IDLE;
    if (onesCnt == (SELECT_WIDTH+1)'(1)) begin
      wrKind = WR_LEGAL;
    end else if (onesCnt > (SELECT_WIDTH+1)'(1)) begin
      wrKind = WR_MULTI;
    end
  end

  assign legal = (wrKind == WR_LEGAL);
  // A write under reset is lost, so it must not be forwarded either.
  assign commit = legal && !rst && !((ZERO_REG != 0) && (wrIdx == '0));

  for (genvar i = 0; i < N; i++) begin : gRegs
    assign load[i] = WrEn[i] & legal & ~((ZERO_REG != 0) && (i == 0));

    nbit_register #(
      .WIDTH(DATA_WIDTH)
    ) uReg (
      .clk  (clk),
      .rst  (rst),
      .load (load[i]),
      .d    (WrData),
      .q    (regQ[i])
    );
  end

  always_comb begin
    RdDataA = regQ[RdAddrA];
    if ((ZERO_REG != 0) && (RdAddrA == '0)) begin
      RdDataA = '0;
    end else if (commit && (RdAddrA == wrIdx)) begin
      RdDataA = WrData;
    end
  end

  always_comb begin
    RdDataB = regQ[RdAddrB];
    if ((ZERO_REG != 0) && (RdAddrB == '0)) begin
      RdDataB = '0;
    end else if (commit && (RdAddrB == wrIdx)) begin
      RdDataB = WrData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ErrMulti <= 1'b0;
      WrCount  <= '0;
    end else begin
      if (wrKind == WR_MULTI) begin
        ErrMulti <= 1'b1;
      end
      if (commit && (WrCount != '1)) begin
        WrCount <= WrCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nbit_regfile_onehot.sv
// Directed bench for nbit_regfile_onehot (8 x 32-bit, zero register on, 4-bit write counter).
module tb_nbit_regfile_onehot;

  logic        clk;
  logic        rst;
  logic [7:0]  WrEn;
  logic [31:0] WrData;
  logic [2:0]  RdAddrA;
  logic [2:0]  RdAddrB;
  logic [31:0] RdDataA;
  logic [31:0] RdDataB;
  logic        ErrMulti;
  logic [3:0]  WrCount;

  int nChecks = 0;
  int nFails  = 0;

  nbit_regfile_onehot #(
    .SELECT_WIDTH(3),
    .DATA_WIDTH  (32),
    .ZERO_REG    (1),
    .CNT_WIDTH   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .WrEn     (WrEn),
    .WrData   (WrData),
    .RdAddrA  (RdAddrA),
    .RdAddrB  (RdAddrB),
    .RdDataA  (RdDataA),
    .RdDataB  (RdDataB),
    .ErrMulti (ErrMulti),
    .WrCount  (WrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic doWrite(input logic [7:0] en, input logic [31:0] d);
    @(negedge clk);
    WrEn   = en;
    WrData = d;
    @(posedge clk);
    #1;
    WrEn   = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; WrEn = '0; WrData = '0; RdAddrA = 3'd1; RdAddrB = 3'd7;
    #2;
    nChecks++; if (RdDataA !== 32'h0) begin nFails++; $display("FAIL reset_rda: got %h want %h", RdDataA, 32'h0); end
    nChecks++; if (RdDataB !== 32'h0) begin nFails++; $display("FAIL reset_rdb: got %h want %h", RdDataB, 32'h0); end
    nChecks++; if (ErrMulti !== 1'b0) begin nFails++; $display("FAIL reset_err: got %b want 0", ErrMulti); end
    nChecks++; if (WrCount !== 4'd0) begin nFails++; $display("FAIL reset_cnt: got %0d want 0", WrCount); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    doWrite(8'b0010_0000, 32'h1234);
    RdAddrA = 3'd5;
    #1;
    nChecks++; if (RdDataA !== 32'h1234) begin nFails++; $display("FAIL wr_rd_r5: got %h want %h", RdDataA, 32'h1234); end
    nChecks++; if (WrCount !== 4'd1) begin nFails++; $display("FAIL wr_rd_cnt: got %0d want 1", WrCount); end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    WrEn = 8'b0000_0100; WrData = 32'hABCD; RdAddrA = 3'd2; RdAddrB = 3'd2;
    #1;
    nChecks++; if (RdDataA !== 32'hABCD) begin nFails++; $display("FAIL byp_a: got %h want %h", RdDataA, 32'hABCD); end
    nChecks++; if (RdDataB !== 32'hABCD) begin nFails++; $display("FAIL byp_b: got %h want %h", RdDataB, 32'hABCD); end
    @(posedge clk);
    #1;
    WrEn = '0; WrData = 32'h0;
    #1;
    nChecks++; if (RdDataA !== 32'hABCD) begin nFails++; $display("FAIL byp_r2_after: got %h want %h", RdDataA, 32'hABCD); end
    nChecks++; if (WrCount !== 4'd2) begin nFails++; $display("FAIL byp_cnt: got %0d want 2", WrCount); end
  endtask

  task automatic test_zero_reg;
    @(negedge clk);
    WrEn = 8'b0000_0001; WrData = 32'hFFFF; RdAddrA = 3'd0; RdAddrB = 3'd5;
    #1;
    nChecks++; if (RdDataA !== 32'h0) begin nFails++; $display("FAIL zero_before: got %h want 0", RdDataA); end
    nChecks++; if (RdDataB !== 32'h1234) begin nFails++; $display("FAIL zero_no_byp_r5: got %h want %h", RdDataB, 32'h1234); end
    @(posedge clk);
    #1;
    WrEn = '0;
    #1;
    nChecks++; if (RdDataA !== 32'h0) begin nFails++; $display("FAIL zero_after: got %h want 0", RdDataA); end
    nChecks++; if (WrCount !== 4'd2) begin nFails++; $display("FAIL zero_cnt: got %0d want 2", WrCount); end
  endtask

  task automatic test_multi_hot;
    doWrite(8'b0000_1000, 32'h1);
    doWrite(8'b0001_0000, 32'h2);
    @(negedge clk);
    WrEn = 8'b0001_1000; WrData = 32'h5555; RdAddrA = 3'd3; RdAddrB = 3'd4;
    #1;
    nChecks++; if (RdDataA !== 32'h1) begin nFails++; $display("FAIL multi_nobyp_a: got %h want 1", RdDataA); end
    nChecks++; if (RdDataB !== 32'h2) begin nFails++; $display("FAIL multi_nobyp_b: got %h want 2", RdDataB); end
    nChecks++; if (ErrMulti !== 1'b0) begin nFails++; $display("FAIL multi_err_early: got %b want 0", ErrMulti); end
    @(posedge clk);
    #1;
    WrEn = '0;
    #1;
    nChecks++; if (RdDataA !== 32'h1) begin nFails++; $display("FAIL multi_r3: got %h want 1", RdDataA); end
    nChecks++; if (RdDataB !== 32'h2) begin nFails++; $display("FAIL multi_r4: got %h want 2", RdDataB); end
    nChecks++; if (ErrMulti !== 1'b1) begin nFails++; $display("FAIL multi_err_set: got %b want 1", ErrMulti); end
    nChecks++; if (WrCount !== 4'd4) begin nFails++; $display("FAIL multi_cnt: got %0d want 4", WrCount); end
    doWrite(8'b0100_0000, 32'h7);
    RdAddrA = 3'd6;
    #1;
    nChecks++; if (ErrMulti !== 1'b1) begin nFails++; $display("FAIL multi_err_sticky: got %b want 1", ErrMulti); end
    nChecks++; if (RdDataA !== 32'h7) begin nFails++; $display("FAIL multi_then_legal: got %h want 7", RdDataA); end
    nChecks++; if (WrCount !== 4'd5) begin nFails++; $display("FAIL multi_then_cnt: got %0d want 5", WrCount); end
  endtask

  task automatic test_reset_mid;
    doWrite(8'b0000_1000, 32'hDEAD);
    RdAddrA = 3'd3; RdAddrB = 3'd2;
    #1;
    nChecks++; if (RdDataA !== 32'hDEAD) begin nFails++; $display("FAIL rstmid_pre: got %h want %h", RdDataA, 32'hDEAD); end
    @(negedge clk);
    WrEn = 8'b0000_1000; WrData = 32'hBEEF;
    #2;
    rst = 1'b1;
    #1;
    nChecks++; if (RdDataA !== 32'h0) begin nFails++; $display("FAIL rstmid_rda: got %h want 0", RdDataA); end
    nChecks++; if (RdDataB !== 32'h0) begin nFails++; $display("FAIL rstmid_rdb: got %h want 0", RdDataB); end
    nChecks++; if (ErrMulti !== 1'b0) begin nFails++; $display("FAIL rstmid_err: got %b want 0", ErrMulti); end
    nChecks++; if (WrCount !== 4'd0) begin nFails++; $display("FAIL rstmid_cnt: got %0d want 0", WrCount); end
    @(posedge clk);
    #1;
    WrEn = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    nChecks++; if (RdDataA !== 32'h0) begin nFails++; $display("FAIL rstmid_write_lost: got %h want 0", RdDataA); end
  endtask

  task automatic test_saturation;
    RdAddrA = 3'd1;
    for (int i = 0; i < 17; i++) begin
      doWrite(8'b0000_0010, 32'h100 + i);
      if (i == 13) begin
        nChecks++; if (WrCount !== 4'd14) begin nFails++; $display("FAIL sat_cnt14: got %0d want 14", WrCount); end
      end
      if (i == 14) begin
        nChecks++; if (WrCount !== 4'd15) begin nFails++; $display("FAIL sat_cnt15: got %0d want 15", WrCount); end
      end
    end
    #1;
    nChecks++; if (WrCount !== 4'd15) begin nFails++; $display("FAIL sat_hold: got %0d want 15", WrCount); end
    nChecks++; if (RdDataA !== 32'h110) begin nFails++; $display("FAIL sat_r1: got %h want %h", RdDataA, 32'h110); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_multi_hot();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
